add64_seq: RTL and testbench
============================

ADD64_SEQ -- requirements
Module: add64_seq

Parameters
REQ-001 SHALL have parameter NSLICE, default 4: number of 16-bit slices; operand width W = 16*NSLICE.

Interface
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = A+B, 1 = A-B; captured with start.
REQ-006 SHALL have port op_a  input  W  operand A; captured with start.
REQ-007 SHALL have port op_b  input  W  operand B; captured with start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port sum  output  W  result; held until the next accepted start.
REQ-011 SHALL have port cout  output  1  carry out of the MSB; for sub, 1 = no borrow (A >= B unsigned).
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-013 SHALL have port add_A  output  16  A slice to the external 16-bit adder.
REQ-014 SHALL have port add_B  output  16  effective B slice to the external adder.
REQ-015 SHALL have port add_Cin  output  1  carry in to the external adder.
REQ-016 SHALL have port add_S  input  16  sum from the external adder; combinational from add_A/add_B/add_Cin.
REQ-017 SHALL have port add_Cout  input  1  carry out from the external adder.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; transitions: IDLE->RUN on start; RUN->DONE after slice NSLICE-1; DONE->IDLE unconditionally.
REQ-019 On an accepted start, SHALL register op_a, effective B (op_b if sub=0, ~op_b if sub=1), carry register = sub, slice index = 0, and clear sum, cout and ovf to 0.
REQ-020 In RUN, SHALL drive add_A = A[16*idx +: 16], add_B = Beff[16*idx +: 16] and add_Cin = carry register; at the clock edge, SHALL store add_S into sum[16*idx +: 16], load carry register from add_Cout and increment idx.
REQ-021 On the last slice edge, SHALL set cout = add_Cout and ovf = (A[W-1] == Beff[W-1]) && (add_S[15] != A[W-1]).
REQ-022 In IDLE and DONE, SHALL drive add_A, add_B and add_Cin to 0.
REQ-023 Latency: start sampled high at edge T SHALL produce done high during cycle T+NSLICE+1; busy SHALL be high from T+1 through the done cycle.
REQ-024 start in RUN or DONE SHALL be ignored, with no queuing; start in the first IDLE cycle after DONE SHALL be accepted, giving a back-to-back period of NSLICE+2 cycles.
REQ-025 op_a, op_b and sub changes after acceptance SHALL NOT affect the operation in flight.
REQ-026 The slice index SHALL be ceil(log2(NSLICE)) bits wide, or 1 bit when NSLICE = 1, and SHALL never exceed NSLICE-1.

Reset
REQ-027 When rst is sampled high, on that edge SHALL force state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, idx = 0, carry register = 0, and internal operand registers = 0; rst SHALL override start.
REQ-028 rst during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL operate normally.

Verification
Bench connects add_A/add_B/add_Cin/add_S/add_Cout to a 16-bit ripple-carry adder; NSLICE = 4.
REQ-029 Scenario: rst held for 2 cycles -> busy = 0, done = 0, sum = 0, cout = 0, ovf = 0, add_A = add_B = 0, add_Cin = 0.
REQ-030 Scenario: add 0x0000_0000_0000_FFFF + 0x1, start at edge T -> done during cycle T+5 with sum = 0x0000_0000_0001_0000, cout = 0, ovf = 0; carry propagates from slice 0 to slice 1.
REQ-031 Scenario: add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> sum = 0, cout = 1, ovf = 0.
REQ-032 Scenario: sub 0x7FFF_FFFF_FFFF_FFFF - 0xFFFF_FFFF_FFFF_FFFF -> sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0; separately, sub 5 - 3 -> sum = 2, cout = 1, ovf = 0.
REQ-033 Scenario: start held high continuously and operands changed mid-operation -> exactly one done per NSLICE+2 cycles; each result matches the operands captured at acceptance.
REQ-034 Scenario: rst pulsed while idx = 2 -> no done; all outputs read 0; a following 1 + 1 operation returns sum = 2.

Source files
------------

// File: rtl/add64_seq.sv
// -----------------------------------------------------------------------------
// add64_seq
// Sequential W-bit adder/subtractor (W = 16*NSLICE) that borrows one external
// 16-bit adder and walks the operands through it one slice per clock,
// least-significant slice first, rippling the carry through a register.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin an operation (only looked at while idle)
//   sub       in   0: A+B, 1: A-B (captured with start)
//   op_a      in   W  operand A (captured with start)
//   op_b      in   W  operand B (captured with start)
//   busy      out  high while an operation is running or completing
//   done      out  one-cycle pulse, result valid
//   sum       out  W  result, held until the next accepted start
//   cout      out  carry out of the MSB (for sub: 1 = no borrow)
//   ovf       out  two's-complement overflow
//   add_A     out  16 A slice to the external adder
//   add_B     out  16 effective B slice to the external adder
//   add_Cin   out  carry into the external adder
//   add_S     in   16 external adder sum (combinational)
//   add_Cout  in   external adder carry out
// -----------------------------------------------------------------------------
module add64_seq #(
    parameter int NSLICE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [16*NSLICE-1:0]   op_a,
    input  logic [16*NSLICE-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [16*NSLICE-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic [15:0]            add_A,
    output logic [15:0]            add_B,
    output logic                   add_Cin,
    input  logic [15:0]            add_S,
    input  logic                   add_Cout
);

    localparam int W  = 16 * NSLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;       // B already inverted for subtraction
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_done;
    logic          r_busy;

    logic [15:0]   w_slice_a;
    logic [15:0]   w_slice_b;
    logic [15:0]   w_add_a;
    logic [15:0]   w_add_b;
    logic          w_add_cin;

    // Select the current slice of A and effective B with an AND-OR mux.
    always_comb begin
        w_slice_a = 16'd0;
        w_slice_b = 16'd0;
        for (int i = 0; i < NSLICE; i++) begin
            w_slice_a = w_slice_a | ({16{r_idx == IW'(i)}} & r_a[16*i +: 16]);
            w_slice_b = w_slice_b | ({16{r_idx == IW'(i)}} & r_b[16*i +: 16]);
        end
    end

    // Present operands to the external adder only while running; quiet otherwise.
    always_comb begin
        w_add_a   = 16'd0;
        w_add_b   = 16'd0;
        w_add_cin = 1'b0;
        if (r_state == S_RUN) begin
            w_add_a   = w_slice_a;
            w_add_b   = w_slice_b;
            w_add_cin = r_carry;
        end else begin
            w_add_a   = 16'd0;
            w_add_b   = 16'd0;
            w_add_cin = 1'b0;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        // Carry-in of 1 with inverted B forms the two's complement.
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_sum[16*i +: 16] <= add_S;
                        end
                    end
                    r_carry <= add_Cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_cout  <= add_Cout;
                        // Same-sign operands whose result sign differs overflowed.
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (add_S[15] != r_a[W-1]);
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign ovf     = r_ovf;
    assign add_A   = w_add_a;
    assign add_B   = w_add_b;
    assign add_Cin = w_add_cin;

endmodule

// File: tb/tb_add64_seq.sv
// -----------------------------------------------------------------------------
// tb_add64_seq
// Scoreboard bench for add64_seq (NSLICE = 4). Stimulus pushes the expected
// result (from plain 64-bit arithmetic) plus the cycle at which done must
// appear; an independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_add64_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [15:0] add_A;
    logic [15:0] add_B;
    logic        add_Cin;
    logic [15:0] add_S;
    logic        add_Cout;

    typedef struct packed {
        logic [63:0] r;
        logic        co;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    add64_seq #(.NSLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf),
        .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
        .add_S(add_S), .add_Cout(add_Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External 16-bit ripple-carry adder.
    logic        rc_c;
    logic [15:0] rc_s;
    always_comb begin
        rc_c = add_Cin;
        rc_s = 16'd0;
        for (int i = 0; i < 16; i++) begin
            rc_s[i] = add_A[i] ^ add_B[i] ^ rc_c;
            rc_c    = (add_A[i] & add_B[i]) | (rc_c & (add_A[i] ^ add_B[i]));
        end
        add_S    = rc_s;
        add_Cout = rc_c;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input int done_cyc);
        exp_t e;
        logic [64:0] full;
        if (!s) begin
            full = {1'b0, a} + {1'b0, b};
            e.r  = full[63:0];
            e.co = full[64];
            e.ov = (a[63] == b[63]) && (e.r[63] != a[63]);
        end else begin
            e.r  = a - b;
            e.co = (a >= b);
            e.ov = (a[63] != b[63]) && (e.r[63] != a[63]);
        end
        e.cyc = done_cyc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sum",      sum,        e.r);
                check("cout",     {63'd0, cout}, {63'd0, e.co});
                check("ovf",      {63'd0, ovf},  {63'd0, e.ov});
                check("done_cyc", 64'(cyc),   64'(e.cyc));
                check("busy_at_done", {63'd0, busy}, 64'd1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 64'd1, 64'd0);
    endtask

    // Issue one operation; called at a negedge, returns one negedge later.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s);
        wait_idle();
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
        // Accept edge makes cyc = cyc+1; done appears 4 cycles after that.
        sb.push_back(model(a, b, s, cyc + 1 + 4));
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the operation in flight must not see them.
        op_a  = {$urandom, $urandom};
        op_b  = {$urandom, $urandom};
        sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},  {63'd0, busy},    64'd0);
        check({tag, "_done"},  {63'd0, done},    64'd0);
        check({tag, "_sum"},   sum,              64'd0);
        check({tag, "_cout"},  {63'd0, cout},    64'd0);
        check({tag, "_ovf"},   {63'd0, ovf},     64'd0);
        check({tag, "_addA"},  {48'd0, add_A},   64'd0);
        check({tag, "_addB"},  {48'd0, add_B},   64'd0);
        check({tag, "_cin"},   {63'd0, add_Cin}, 64'd0);
    endtask

    initial begin
        exp_t  held;
        logic  ra_s;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = 64'd0;
        op_b  = 64'd0;

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases.
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        do_op(64'd5, 64'd3, 1'b1);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        do_op(64'd3, 64'd5, 1'b1);
        drain();

        // Result held after done, and adder port quiet while idle.
        held = model(64'd3, 64'd5, 1'b1, 0);
        check("sum_held", sum, held.r);
        check("idle_addA", {48'd0, add_A}, 64'd0);

        // Randomized operations.
        for (int k = 0; k < 20; k++) begin
            ra_s = 1'($urandom_range(0, 1));
            do_op({$urandom, $urandom}, {$urandom, $urandom}, ra_s);
        end
        drain();

        // Start held high with operands changing every cycle.
        wait_idle();
        for (int k = 0; k < 18; k++) begin
            start = 1'b1;
            op_a  = {$urandom, $urandom};
            op_b  = {$urandom, $urandom};
            sub   = 1'($urandom_range(0, 1));
            if (k % 6 == 0) sb.push_back(model(op_a, op_b, sub, cyc + 1 + 4));
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Abort with reset while slice 2 is being processed.
        wait_idle();
        start = 1'b1;
        op_a  = 64'h1234_5678_9ABC_DEF0;
        op_b  = 64'h0FED_CBA9_8765_4321;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("abort");
        for (int k = 0; k < 8; k++) @(negedge clk);
        do_op(64'd1, 64'd1, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
